// File: rtl/stream_tile_extractor_if.sv
// Pixel-in / tile-out handshake bundle for stream_tile_extractor.
// master = image source and tile sink side; slave = the tiler itself.
interface stream_tile_extractor_if #(
    parameter int DW   = 32,
    parameter int TILE = 3,
    parameter int IW   = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [DW-1:0]          in_pix;
    logic                   out_valid;
    logic                   out_ready;
    logic [TILE*TILE*DW-1:0] out_tile;
    logic [IW-1:0]          out_idx;
    logic                   out_last;

    modport master (
        output in_valid, in_pix, out_ready,
        input  in_ready, out_valid, out_tile, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_pix, out_ready,
        output in_ready, out_valid, out_tile, out_idx, out_last
    );
endinterface

// File: rtl/stream_tile_extractor.sv
// Buffers one IMGxIMG raster image, then emits TILExTILE windows at STRIDE.
// Optional macro TILER_ZERO_PAD_EN: ceil tile count, out-of-image pixels read 0.
module stream_tile_extractor #(
    parameter int DW     = 32,
    parameter int IMG    = 9,
    parameter int TILE   = 3,
    parameter int STRIDE = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    stream_tile_extractor_if.slave bus
);

`ifdef TILER_ZERO_PAD_EN
    localparam int NT  = (IMG - TILE + STRIDE - 1) / STRIDE + 1;
`else
    localparam int NT  = (IMG - TILE) / STRIDE + 1;
`endif
    localparam int NTT = NT * NT;
    localparam int IW  = (NTT > 1) ? $clog2(NTT) : 1;
    localparam int TW  = (NT > 1) ? $clog2(NT) : 1;
    localparam int PW  = (IMG > 1) ? $clog2(IMG) : 1;
    localparam int AW  = (IMG * IMG > 1) ? $clog2(IMG * IMG) : 1;
    localparam int OW  = $clog2(IMG + STRIDE + 1);
    localparam int TD  = TILE * TILE * DW;

    generate
        if (TILE < 1 || STRIDE < 1 || TILE > IMG || STRIDE > TILE) begin : g_bad_param
            $error("stream_tile_extractor: illegal IMG/TILE/STRIDE combination");
        end
    endgenerate

    typedef enum logic {
        LOAD = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t         state_q;
    state_t         state_d;

    logic [DW-1:0]  img_mem [IMG*IMG];

    logic [PW-1:0]  prow;
    logic [PW-1:0]  pcol;
    logic [TW-1:0]  tcol;
    logic [OW-1:0]  orow;
    logic [OW-1:0]  ocol;

    logic           in_ready;
    logic           out_valid_q;
    logic [TD-1:0]  out_tile_q;
    logic [IW-1:0]  out_idx_q;
    logic           out_last_q;

    logic           last_pix;
    logic           in_fire;
    logic           out_fire;
    logic           load_tile;
    logic           bypass;

    logic [OW-1:0]  nrow;
    logic [OW-1:0]  ncol;
    logic [TW-1:0]  ntcol;
    logic [IW-1:0]  nidx;
    logic           nlast;
    logic [TD-1:0]  ntile;

    assign last_pix  = (prow == PW'(IMG - 1)) && (pcol == PW'(IMG - 1));
    assign in_fire   = bus.in_valid && in_ready;
    assign out_fire  = out_valid_q && bus.out_ready;
    assign load_tile = (in_fire && last_pix) || (out_fire && !out_last_q);
    assign bypass    = (state_q == LOAD);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= LOAD;
        else        state_q <= state_d;
    end

    // Next state and input-side ready
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        unique case (state_q)
            LOAD: begin
                in_ready = 1'b1;
                if (bus.in_valid && last_pix) state_d = EMIT;
            end
            EMIT: begin
                if (out_fire && out_last_q) state_d = LOAD;
            end
        endcase
    end

    // Image buffer write; contents need no reset
    always_ff @(posedge clk) begin
        if (in_fire) img_mem[AW'(int'(prow) * IMG + int'(pcol))] <= bus.in_pix;
    end

    // Raster pixel counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prow <= '0;
            pcol <= '0;
        end else if (in_fire) begin
            if (last_pix) begin
                prow <= '0;
                pcol <= '0;
            end else if (pcol == PW'(IMG - 1)) begin
                pcol <= '0;
                prow <= prow + 1'b1;
            end else begin
                pcol <= pcol + 1'b1;
            end
        end
    end

    // Origin and index of the tile that the next load will present
    always_comb begin
        nrow  = '0;
        ncol  = '0;
        ntcol = '0;
        nidx  = '0;
        nlast = (NTT == 1);
        if (state_q == EMIT) begin
            nidx  = out_idx_q + 1'b1;
            nlast = (nidx == IW'(NTT - 1));
            if (tcol == TW'(NT - 1)) begin
                nrow = orow + OW'(STRIDE);
            end else begin
                nrow  = orow;
                ncol  = ocol + OW'(STRIDE);
                ntcol = tcol + 1'b1;
            end
        end
    end

    // Window gather; the last input pixel bypasses the buffer write
    always_comb begin
        ntile = '0;
        for (int r = 0; r < TILE; r++) begin
            for (int c = 0; c < TILE; c++) begin
                int pr;
                int pc;
                pr = int'(nrow) + r;
                pc = int'(ncol) + c;
`ifdef TILER_ZERO_PAD_EN
                if (pr < IMG && pc < IMG) begin
`else
                begin
`endif
                    if (bypass && pr == IMG - 1 && pc == IMG - 1)
                        ntile[(r*TILE+c)*DW +: DW] = bus.in_pix;
                    else
                        ntile[(r*TILE+c)*DW +: DW] = img_mem[AW'(pr * IMG + pc)];
                end
            end
        end
    end

    // Output tile registers and tile-grid position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_tile_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            orow        <= '0;
            ocol        <= '0;
            tcol        <= '0;
        end else if (load_tile) begin
            out_valid_q <= 1'b1;
            out_tile_q  <= ntile;
            out_idx_q   <= nidx;
            out_last_q  <= nlast;
            orow        <= nrow;
            ocol        <= ncol;
            tcol        <= ntcol;
        end else if (out_fire) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_tile  = out_tile_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_stream_tile_extractor.sv
// Directed bench for stream_tile_extractor: three geometries side by side.
// Follows TILER_ZERO_PAD_EN to pick the IMG=8 expectations.
module tb_stream_tile_extractor;

`ifdef TILER_ZERO_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif
    localparam int TD  = 288;
    localparam int IW2 = PAD ? 4 : 2;

    typedef struct {
        int          d;
        int          t;
        int          r;
        int          c;
        logic [31:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          iv   [3];
    logic [31:0]   px   [3];
    logic          ordy [3];
    logic          irdy [3];
    logic          ov   [3];
    logic          ol   [3];
    logic [7:0]    oidx [3];
    logic [TD-1:0] otile[3];

    logic [TD-1:0] cap [3][16];
    int img_of [3];
    int str_of [3];
    int nt_of  [3];
    int ntt_of [3];
    int n_chk = 0;
    int n_fail = 0;
    vec_t tab[$];

    stream_tile_extractor_if #(.DW(32), .TILE(3), .IW(4))   b0 ();
    stream_tile_extractor_if #(.DW(32), .TILE(3), .IW(4))   b1 ();
    stream_tile_extractor_if #(.DW(32), .TILE(3), .IW(IW2)) b2 ();

    assign b0.in_valid = iv[0];
    assign b0.in_pix = px[0];
    assign b0.out_ready = ordy[0];
    assign irdy[0] = b0.in_ready;
    assign ov[0] = b0.out_valid;
    assign ol[0] = b0.out_last;
    assign oidx[0] = 8'(b0.out_idx);
    assign otile[0] = b0.out_tile;

    assign b1.in_valid = iv[1];
    assign b1.in_pix = px[1];
    assign b1.out_ready = ordy[1];
    assign irdy[1] = b1.in_ready;
    assign ov[1] = b1.out_valid;
    assign ol[1] = b1.out_last;
    assign oidx[1] = 8'(b1.out_idx);
    assign otile[1] = b1.out_tile;

    assign b2.in_valid = iv[2];
    assign b2.in_pix = px[2];
    assign b2.out_ready = ordy[2];
    assign irdy[2] = b2.in_ready;
    assign ov[2] = b2.out_valid;
    assign ol[2] = b2.out_last;
    assign oidx[2] = 8'(b2.out_idx);
    assign otile[2] = b2.out_tile;

    stream_tile_extractor #(.DW(32), .IMG(9), .TILE(3), .STRIDE(3)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(b0.slave));
    stream_tile_extractor #(.DW(32), .IMG(9), .TILE(3), .STRIDE(2)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(b1.slave));
    stream_tile_extractor #(.DW(32), .IMG(8), .TILE(3), .STRIDE(3)) u2 (
        .clk(clk), .rst_n(rst_n), .bus(b2.slave));

    task automatic chk(input string name, input logic [TD-1:0] act,
                       input logic [TD-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input int d, input int t, input int r, input int c,
                       input int e);
        vec_t v;
        v.d = d;
        v.t = t;
        v.r = r;
        v.c = c;
        v.exp = 32'(e);
        tab.push_back(v);
    endtask

    // Reference window: pixel (r,c) of image carries r*IMG+c, outside reads 0
    function automatic logic [TD-1:0] model(input int d, input int t);
        logic [TD-1:0] m;
        int img, orr, occ, pr, pc;
        m = '0;
        img = img_of[d];
        orr = (t / nt_of[d]) * str_of[d];
        occ = (t % nt_of[d]) * str_of[d];
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                pr = orr + r;
                pc = occ + c;
                if (pr < img && pc < img)
                    m[(r*3+c)*32 +: 32] = 32'(pr * img + pc);
            end
        end
        return m;
    endfunction

    task automatic load_image(input int d, input int n);
        int npix;
        npix = img_of[d] * img_of[d];
        for (int k = 0; k < n; k++) begin
            iv[d] = 1'b1;
            px[d] = 32'(k);
            if (k == 0)
                chk($sformatf("d%0d in_ready at load start", d),
                    TD'(irdy[d]), TD'(1));
            if (k == npix - 1)
                chk($sformatf("d%0d out_valid low before latency", d),
                    TD'(ov[d]), TD'(0));
            tick();
        end
        iv[d] = 1'b0;
        px[d] = '0;
    endtask

    task automatic collect(input int d, input int stall);
        logic [TD-1:0] held;
        int ntt;
        ntt = ntt_of[d];
        for (int t = 0; t < ntt; t++) begin
            if (t == stall) begin
                ordy[d] = 1'b0;
                iv[d] = 1'b1;
                px[d] = 32'hDEAD_BEEF;
                held = otile[d];
                for (int s = 0; s < 5; s++) begin
                    tick();
                    chk($sformatf("d%0d stall%0d out_valid", d, s), TD'(ov[d]), TD'(1));
                    chk($sformatf("d%0d stall%0d out_idx", d, s), TD'(oidx[d]), TD'(t));
                    chk($sformatf("d%0d stall%0d out_tile", d, s), otile[d], held);
                    chk($sformatf("d%0d stall%0d in_ready", d, s), TD'(irdy[d]), TD'(0));
                end
                iv[d] = 1'b0;
                px[d] = '0;
            end
            ordy[d] = 1'b1;
            chk($sformatf("d%0d t%0d out_valid", d, t), TD'(ov[d]), TD'(1));
            chk($sformatf("d%0d t%0d out_idx", d, t), TD'(oidx[d]), TD'(t));
            chk($sformatf("d%0d t%0d out_last", d, t), TD'(ol[d]), TD'(t == ntt - 1));
            chk($sformatf("d%0d t%0d out_tile", d, t), otile[d], model(d, t));
            chk($sformatf("d%0d t%0d in_ready", d, t), TD'(irdy[d]), TD'(0));
            cap[d][t] = otile[d];
            tick();
        end
        ordy[d] = 1'b0;
        chk($sformatf("d%0d after last out_valid", d), TD'(ov[d]), TD'(0));
        chk($sformatf("d%0d after last in_ready", d), TD'(irdy[d]), TD'(1));
    endtask

    initial begin
        int t0 [9];
        int t1 [9];
        int t2 [9];
        img_of = '{9, 9, 8};
        str_of = '{3, 2, 3};
        nt_of  = '{3, 4, PAD ? 3 : 2};
        ntt_of = '{9, 16, PAD ? 9 : 4};
        for (int d = 0; d < 3; d++) begin
            iv[d] = 1'b0;
            px[d] = '0;
            ordy[d] = 1'b0;
            for (int t = 0; t < 16; t++) cap[d][t] = '0;
        end

        t0 = '{0, 1, 2, 9, 10, 11, 18, 19, 20};
        t1 = '{2, 3, 4, 11, 12, 13, 20, 21, 22};
        t2 = '{6, 7, 0, 14, 15, 0, 22, 23, 0};
        for (int i = 0; i < 9; i++) add(0, 0, i / 3, i % 3, t0[i]);
        add(0, 4, 0, 0, 30);
        for (int i = 0; i < 9; i++) add(1, 1, i / 3, i % 3, t1[i]);
        add(1, 15, 2, 2, 80);
        if (PAD) begin
            for (int i = 0; i < 9; i++) add(2, 2, i / 3, i % 3, t2[i]);
        end else begin
            add(2, 3, 0, 0, 27);
        end

        #2;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("d%0d reset in_ready", d), TD'(irdy[d]), TD'(1));
            chk($sformatf("d%0d reset out_valid", d), TD'(ov[d]), TD'(0));
            chk($sformatf("d%0d reset out_idx", d), TD'(oidx[d]), TD'(0));
            chk($sformatf("d%0d reset out_last", d), TD'(ol[d]), TD'(0));
            chk($sformatf("d%0d reset out_tile", d), otile[d], TD'(0));
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        load_image(0, 81);
        collect(0, -1);

        load_image(0, 81);
        collect(0, 2);
        load_image(0, 81);
        collect(0, -1);

        load_image(1, 81);
        collect(1, -1);

        load_image(2, 64);
        collect(2, -1);

        load_image(0, 41);
        rst_n = 1'b0;
        #1;
        chk("mid reset in_ready", TD'(irdy[0]), TD'(1));
        chk("mid reset out_valid", TD'(ov[0]), TD'(0));
        tick();
        chk("mid reset held in_ready", TD'(irdy[0]), TD'(1));
        chk("mid reset held out_valid", TD'(ov[0]), TD'(0));
        rst_n = 1'b1;
        tick();
        load_image(0, 81);
        collect(0, -1);

        foreach (tab[i]) begin
            chk($sformatf("vec%0d d%0d t%0d (%0d,%0d)", i, tab[i].d, tab[i].t,
                          tab[i].r, tab[i].c),
                TD'(cap[tab[i].d][tab[i].t][(tab[i].r*3+tab[i].c)*32 +: 32]),
                TD'(tab[i].exp));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
